ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite slave fronting a single-port, byte-enabled SRAM bank.
//  - Consumes the address/control/write-data stream produced by the CPU-side AHB master wrappers after arbitration and decode.
//  - Returns HRead_data/HReady_out/HResp to those masters.
//  - Supports programmable wait states, byte/half/word transfers and two-cycle ERROR responses.
// PARAMETERS
//  ADDR_W       14  byte-address bits decoded in-bank; DEPTH = 2**(ADDR_W-2) 32-bit words
//  WAIT_STATES  0   extra HReady_out=0 cycles per OKAY transfer; legal range 0..7
// PORTS
//  clk          in   1                 system clock, all flops rising edge
//  rst          in   1                 asynchronous, active-high reset
//  HSel         in   1                 slave select from address decoder
//  HAddress     in   32                byte address; [31:28] region nibble ignored here
//  HTrans       in   `AHB_TRANS_BITS   IDLE/BUSY/NONSEQ/SEQ
//  HSize        in   `AHB_SIZE_BITS    0=byte 1=half 2=word; >2 illegal
//  HWrite       in   1                 1=write, 0=read
//  HWrite_data  in   32                write data, valid in data phase
//  HReady       in   1                 bus-level ready (previous transfer completing)
//  HRead_data   out  32                read data, little-endian lanes
//  HReady_out   out  1                 this slave's data-phase ready
//  HResp        out  2                 OKAY/ERROR (RETRY/SPLIT never issued)
// BEHAVIOUR
//  - Reset values:
//    - HReady_out=1, HResp=OKAY, HRead_data=0, FSM=IDLE, wait counter=0.
//    - Pending data-phase write discarded; SRAM contents not reset.
//  - Address phase is accepted on a rising edge when HSel & HReady & HTrans is NONSEQ or SEQ.
//    - Registers word address, lane byte-enables, HWrite, error flag.
//    - Issues the SRAM read on that same edge.
//  - IDLE/BUSY with HSel=1, or HSel=0:
//    - Next data phase is OKAY with zero wait.
//    - No SRAM access.
//  - Error check at the address phase; any of the following is an error:
//    - HSize>2.
//    - Half with addr[0]=1.
//    - Word with addr[1:0]!=0.
//    - addr[27:ADDR_W]!=0.
//  - FSM states IDLE, WAIT, ERR1, ERR2:
//    - IDLE: accepted error -> ERR1. Accepted legal transfer -> WAIT if WAIT_STATES>0, else complete in the next cycle.
//    - WAIT: HReady_out=0, HResp=OKAY. Counter counts WAIT_STATES..1; at 1, the next cycle completes.
//    - Completion cycle: HReady_out=1, HResp=OKAY. A new address phase may be accepted in the same cycle (pipelined).
//    - ERR1: HReady_out=0, HResp=ERROR -> ERR2.
//    - ERR2: HReady_out=1, HResp=ERROR -> IDLE or next accepted transfer. No wait states on errors.
//  - Writes:
//    - SRAM written on the completion edge.
//    - Byte lane = addr[1:0]; half lanes = addr[1]?[3:2]:[1:0]; word = all lanes.
//    - Lanes taken from the matching HWrite_data bytes.
//    - Erroring writes never touch SRAM.
//  - Reads:
//    - HRead_data = full word during the read completion cycle, 0 otherwise.
//    - Master extracts lanes.
//  - Read-after-write hazard: the read address phase coincides with the completion of a write to the same word.
//    - Written lanes are forwarded into the read data.
//    - The read returns the post-write value; no extra wait.
//  - Reset asserted mid-transfer: outputs return to reset values immediately (async). In-flight transfer dropped.
// STRUCTURE
//  - Package ahb_pkg holds:
//    - HTRANS enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
//    - HRESP constants (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
//    - HSIZE constants.
//    - Slave FSM state typedef.
//  - Sub-module sram_bank: synchronous read, per-byte write enable, DEPTH x 32, no reset.
//  - Top contains the FSM, lane decode, error check and forwarding mux.
// TESTING
//  1. Reset: assert rst during WAIT with WAIT_STATES=2 -> HReady_out=1, HResp=0, HRead_data=0 at once; next transfer completes normally.
//  2. Word write/read, WAIT_STATES=0:
//     - Write 0xDEADBEEF to 0x1000_0010, then read -> each completes one cycle after its address phase.
//     - Read returns 0xDEADBEEF.
//  3. Byte write 0xAA to 0x1000_0013, back-to-back word read of 0x1000_0010 -> forwarding yields 0xAAADBEEF.
//  4. WAIT_STATES=2, word read -> HReady_out 0,0,1 in data phase; HResp OKAY throughout; data valid only on the final cycle.
//  5. Misaligned word read at 0x1000_0012 -> HReady_out 0 then 1, HResp ERROR both cycles; subsequent read of 0x10 still 0xAAADBEEF.
//  6. Out-of-range write (addr[27:ADDR_W]!=0) then IDLE with HSel=1 -> ERROR two cycles, then OKAY zero-wait; no SRAM write observed.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and slave FSM state type
package ahb_pkg;

  localparam int AHB_TRANS_W = 2;
  localparam int AHB_SIZE_W  = 3;
  localparam int AHB_RESP_W  = 2;

  typedef enum logic [AHB_TRANS_W-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [AHB_RESP_W-1:0] HRESP_OKAY  = 2'd0;
  localparam logic [AHB_RESP_W-1:0] HRESP_ERROR = 2'd1;
  localparam logic [AHB_RESP_W-1:0] HRESP_RETRY = 2'd2;
  localparam logic [AHB_RESP_W-1:0] HRESP_SPLIT = 2'd3;

  localparam logic [AHB_SIZE_W-1:0] HSIZE_BYTE = 3'd0;
  localparam logic [AHB_SIZE_W-1:0] HSIZE_HALF = 3'd1;
  localparam logic [AHB_SIZE_W-1:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  // Byte lanes touched by a legal transfer of the given size at the given low address bits.
  function automatic logic [3:0] lane_mask(input logic [AHB_SIZE_W-1:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - DEPTH x 32 SRAM, synchronous read, per-byte write enables
module sram_bank #(
  parameter int DEPTH_W = 12
) (
  input  logic               clk,
  input  logic               re,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [31:0]        rdata,
  input  logic [3:0]         wbe,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [31:0]        wdata
);

  logic [31:0] mem [0:(1<<DEPTH_W)-1];

  // Byte-lane writes and registered read; a same-edge read of the written word returns the old value.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave in front of a byte-enabled SRAM bank
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSel,
  input  logic [31:0]           HAddress,
  input  logic [AHB_TRANS_W-1:0] HTrans,
  input  logic [AHB_SIZE_W-1:0] HSize,
  input  logic                  HWrite,
  input  logic [31:0]           HWrite_data,
  input  logic                  HReady,
  output logic [31:0]           HRead_data,
  output logic                  HReady_out,
  output logic [AHB_RESP_W-1:0] HResp
);

  localparam int WORD_W = ADDR_W - 2;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  slv_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              dp_valid_q, dp_write_q;
  logic [3:0]        dp_be_q;
  logic [WORD_W-1:0] dp_word_q;
  logic              fwd_q;
  logic [3:0]        fwd_be_q;
  logic [31:0]       fwd_data_q;
  logic [31:0]       bank_rdata, fwd_mask, merged;

  // Region nibble is decoded upstream.
  logic unused_region;
  assign unused_region = ^HAddress[31:28];

  logic              accept, addr_err, accept_ok, accept_err;
  logic              complete, wr_commit, rd_issue, hazard;
  logic [WORD_W-1:0] new_word;

  assign accept     = HSel & HReady & ((HTrans == HTRANS_NONSEQ) | (HTrans == HTRANS_SEQ));
  assign addr_err   = (HSize > HSIZE_WORD)
                    | ((HSize == HSIZE_HALF) & HAddress[0])
                    | ((HSize == HSIZE_WORD) & (HAddress[1:0] != 2'b00))
                    | (HAddress[27:ADDR_W] != '0);
  assign accept_ok  = accept & ~addr_err;
  assign accept_err = accept & addr_err;
  assign new_word   = HAddress[ADDR_W-1:2];
  assign complete   = (state_q == ST_IDLE) & dp_valid_q;
  assign wr_commit  = complete & dp_write_q;
  assign rd_issue   = accept_ok & ~HWrite;
  // A read issued on the edge that commits a write to the same word sees stale bank data.
  assign hazard     = wr_commit & rd_issue & (dp_word_q == new_word);

  sram_bank #(.DEPTH_W(WORD_W)) u_bank (
    .clk   (clk),
    .re    (rd_issue),
    .raddr (new_word),
    .rdata (bank_rdata),
    .wbe   (wr_commit ? dp_be_q : 4'b0000),
    .waddr (dp_word_q),
    .wdata (HWrite_data)
  );

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus ready/response; IDLE with a pending transfer is the completion cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    HReady_out = 1'b1;
    HResp      = HRESP_OKAY;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (state_q == ST_ERR2) HResp = HRESP_ERROR;
        if (accept_err) begin
          state_d = ST_ERR1;
        end else if (accept_ok && (WAIT_STATES > 0)) begin
          state_d = ST_WAIT;
          cnt_d   = WS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        HReady_out = 1'b0;
        cnt_d      = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_IDLE;
      end
      ST_ERR1: begin
        HReady_out = 1'b0;
        HResp      = HRESP_ERROR;
        state_d    = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the accepted transfer and any write lanes that must be forwarded into its read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_be_q    <= 4'b0000;
      dp_word_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'd0;
    end else begin
      if (accept_ok) begin
        dp_valid_q <= 1'b1;
        dp_write_q <= HWrite;
        dp_be_q    <= lane_mask(HSize, HAddress[1:0]);
        dp_word_q  <= new_word;
      end else if (complete) begin
        dp_valid_q <= 1'b0;
      end
      if (rd_issue) begin
        fwd_q      <= hazard;
        fwd_be_q   <= dp_be_q;
        fwd_data_q <= HWrite_data;
      end
    end
  end

  assign fwd_mask   = {{8{fwd_be_q[3]}}, {8{fwd_be_q[2]}}, {8{fwd_be_q[1]}}, {8{fwd_be_q[0]}}};
  assign merged     = fwd_q ? ((bank_rdata & ~fwd_mask) | (fwd_data_q & fwd_mask)) : bank_rdata;
  assign HRead_data = (complete & ~dp_write_q) ? merged : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_W = 3'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hsel, use_ws2, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hsel_a, hsel_b, ready_a, ready_b, rdy;
  logic [31:0] rdata_a, rdata_b, rdat;
  logic [1:0]  resp_a, resp_b, resp;

  int tests_run = 0;
  int tests_failed = 0;

  assign hsel_a = hsel & ~use_ws2;
  assign hsel_b = hsel & use_ws2;
  assign rdy    = use_ws2 ? ready_b : ready_a;
  assign rdat   = use_ws2 ? rdata_b : rdata_a;
  assign resp   = use_ws2 ? resp_b : resp_a;

  ahb_sram_slave #(.ADDR_W(14), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .HSel(hsel_a), .HAddress(haddr), .HTrans(htrans), .HSize(hsize),
    .HWrite(hwrite), .HWrite_data(hwdata), .HReady(ready_a),
    .HRead_data(rdata_a), .HReady_out(ready_a), .HResp(resp_a)
  );

  ahb_sram_slave #(.ADDR_W(14), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .HSel(hsel_b), .HAddress(haddr), .HTrans(htrans), .HSize(hsize),
    .HWrite(hwrite), .HWrite_data(hwdata), .HReady(ready_b),
    .HRead_data(rdata_b), .HReady_out(ready_b), .HResp(resp_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic [2:0] size, input logic wr);
    hsel = 1'b1; haddr = addr; htrans = trans; hsize = size; hwrite = wr;
  endtask

  task automatic test_reset();
    rst = 1'b1; use_ws2 = 1'b0; hwdata = 32'd0;
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tick(); tick();
    tests_run++; if (ready_a !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_ws0: got %b want 1", ready_a); end
    tests_run++; if (resp_a !== 2'd0) begin tests_failed++; $display("FAIL rst_resp_ws0: got %0d want 0", resp_a); end
    tests_run++; if (rdata_a !== 32'd0) begin tests_failed++; $display("FAIL rst_rdata_ws0: got %h want 0", rdata_a); end
    tests_run++; if (ready_b !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_ws2: got %b want 1", ready_b); end
    tests_run++; if (rdata_b !== 32'd0) begin tests_failed++; $display("FAIL rst_rdata_ws2: got %h want 0", rdata_b); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word_rw();
    use_ws2 = 1'b0;
    drive(32'h1000_0010, T_NSEQ, SZ_W, 1'b1); tick();
    hwdata = 32'hDEAD_BEEF; drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL wr_ready: got %b want 1", rdy); end
    tests_run++; if (resp !== 2'd0) begin tests_failed++; $display("FAIL wr_resp: got %0d want 0", resp); end
    tick();
    drive(32'h1000_0010, T_NSEQ, SZ_W, 1'b0); tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL rd_ready: got %b want 1", rdy); end
    tests_run++; if (rdat !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data: got %h want deadbeef", rdat); end
    tick();
    tests_run++; if (rdat !== 32'd0) begin tests_failed++; $display("FAIL rd_data_idle: got %h want 0", rdat); end
  endtask

  task automatic test_back_to_back();
    use_ws2 = 1'b0;
    drive(32'h1000_0013, T_NSEQ, SZ_B, 1'b1); tick();
    hwdata = 32'hAA11_2233; drive(32'h1000_0010, T_NSEQ, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL b2b_wr_ready: got %b want 1", rdy); end
    tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL b2b_rd_ready: got %b want 1", rdy); end
    tests_run++; if (rdat !== 32'hAAAD_BEEF) begin tests_failed++; $display("FAIL b2b_forward: got %h want aaadbeef", rdat); end
    tick();
  endtask

  task automatic test_wait_states();
    use_ws2 = 1'b1;
    drive(32'h1000_0020, T_NSEQ, SZ_W, 1'b1); tick();
    hwdata = 32'h1234_5678; drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL ws_wr_wait1: got %b want 0", rdy); end
    tick();
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL ws_wr_wait2: got %b want 0", rdy); end
    tick();
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL ws_wr_done: got %b want 1", rdy); end
    tick();
    drive(32'h1000_0020, T_NSEQ, SZ_W, 1'b0); tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tests_run++; if (rdy !== (c == 2)) begin tests_failed++; $display("FAIL ws_rd_ready_c%0d: got %b want %b", c, rdy, (c == 2)); end
      tests_run++; if (resp !== 2'd0) begin tests_failed++; $display("FAIL ws_rd_resp_c%0d: got %0d want 0", c, resp); end
      tests_run++; if (rdat !== ((c == 2) ? 32'h1234_5678 : 32'd0)) begin tests_failed++; $display("FAIL ws_rd_data_c%0d: got %h", c, rdat); end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    use_ws2 = 1'b1;
    drive(32'h1000_0020, T_NSEQ, SZ_W, 1'b0); tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL mid_wait_ready: got %b want 0", rdy); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL async_rst_ready: got %b want 1", rdy); end
    tests_run++; if (resp !== 2'd0) begin tests_failed++; $display("FAIL async_rst_resp: got %0d want 0", resp); end
    tests_run++; if (rdat !== 32'd0) begin tests_failed++; $display("FAIL async_rst_rdata: got %h want 0", rdat); end
    tick();
    rst = 1'b0;
    drive(32'h1000_0020, T_NSEQ, SZ_W, 1'b0); tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tick(); tick();
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL post_rst_ready: got %b want 1", rdy); end
    tests_run++; if (rdat !== 32'h1234_5678) begin tests_failed++; $display("FAIL post_rst_data: got %h want 12345678", rdat); end
    tick();
  endtask

  task automatic test_misaligned();
    use_ws2 = 1'b0;
    drive(32'h1000_0012, T_NSEQ, SZ_W, 1'b0); tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL mis_err1_ready: got %b want 0", rdy); end
    tests_run++; if (resp !== 2'd1) begin tests_failed++; $display("FAIL mis_err1_resp: got %0d want 1", resp); end
    tests_run++; if (rdat !== 32'd0) begin tests_failed++; $display("FAIL mis_err1_rdata: got %h want 0", rdat); end
    tick();
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL mis_err2_ready: got %b want 1", rdy); end
    tests_run++; if (resp !== 2'd1) begin tests_failed++; $display("FAIL mis_err2_resp: got %0d want 1", resp); end
    tick();
    tests_run++; if (resp !== 2'd0) begin tests_failed++; $display("FAIL mis_after_resp: got %0d want 0", resp); end
    drive(32'h1000_0010, T_NSEQ, SZ_W, 1'b0); tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdat !== 32'hAAAD_BEEF) begin tests_failed++; $display("FAIL mis_reread: got %h want aaadbeef", rdat); end
    tick();
  endtask

  task automatic test_out_of_range();
    use_ws2 = 1'b0;
    drive(32'h1000_4010, T_NSEQ, SZ_W, 1'b1); tick();
    hwdata = 32'h0BAD_F00D; drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL oor_err1_ready: got %b want 0", rdy); end
    tests_run++; if (resp !== 2'd1) begin tests_failed++; $display("FAIL oor_err1_resp: got %0d want 1", resp); end
    tick();
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL oor_err2_ready: got %b want 1", rdy); end
    tests_run++; if (resp !== 2'd1) begin tests_failed++; $display("FAIL oor_err2_resp: got %0d want 1", resp); end
    tick();
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL oor_idle_ready: got %b want 1", rdy); end
    tests_run++; if (resp !== 2'd0) begin tests_failed++; $display("FAIL oor_idle_resp: got %0d want 0", resp); end
    drive(32'h1000_0010, T_NSEQ, SZ_W, 1'b0); tick();
    drive(32'd0, T_IDLE, SZ_W, 1'b0);
    tests_run++; if (rdat !== 32'hAAAD_BEEF) begin tests_failed++; $display("FAIL oor_no_write: got %h want aaadbeef", rdat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_wait();
    test_misaligned();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
